i2s_capture_seq: RTL

- Capture sequencer for the I2S receive datapath (I2S master + sample FIFO).
- On a start command it:
  - enables the interface and flushes the FIFO;
  - discards a programmable number of settling samples;
  - waits for a trigger;
  - drains exactly capture_len samples from the FIFO onto a valid/ready stream;
  - then shuts the interface down.
- Sits between the register/bus layer and the I2S block; owns that block's en, fifo_en, fifo_flush and fifo_rd.

---
 rtl/i2s_capture_seq.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/i2s_capture_seq.sv
// Capture sequencer for the I2S receive path: flush, settle, arm,
// then stream exactly capture_len FIFO words out on a valid/ready port.
module i2s_capture_seq #(
  parameter int DW = 32,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [1:0]    trig_mode,
  input  logic [CW-1:0] capture_len,
  input  logic [7:0]    settle_samples,
  input  logic          avg_flag,
  input  logic          ext_trig,
  output logic          i2s_en,
  output logic          fifo_en,
  output logic          fifo_flush,
  output logic          fifo_rd,
  input  logic          fifo_empty,
  input  logic          fifo_full,
  input  logic [DW-1:0] fifo_rdata,
  output logic          m_valid,
  output logic [DW-1:0] m_data,
  output logic          m_last,
  input  logic          m_ready,
  output logic          busy,
  output logic          done,
  output logic          overrun,
  output logic [CW-1:0] captured_cnt
);

  typedef enum logic [2:0] {
    IDLE, FLUSH, SETTLE, ARM, CAPTURE, DONE
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] len_q;
  logic [CW-1:0] issued;
  logic [7:0]    settle_q;
  logic [7:0]    disc_cnt;
  logic          ext_trig_q;
  logic          trig;
  logic          go;
  logic          accept;

  assign go     = (state == IDLE) & start & ~abort;
  assign accept = m_valid & m_ready;
  assign busy   = (state != IDLE);

  always_comb begin
    unique case (trig_mode)
      2'b01:   trig = avg_flag;
      2'b10:   trig = ext_trig & ~ext_trig_q;
      default: trig = 1'b1;
    endcase
  end

  always_comb begin
    state_nx   = state;
    i2s_en     = 1'b0;
    fifo_en    = 1'b0;
    fifo_flush = 1'b0;
    fifo_rd    = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        if (go) state_nx = FLUSH;
      end
      FLUSH: begin
        fifo_flush = 1'b1;
        i2s_en     = 1'b1;
        state_nx   = (settle_q != 8'd0) ? SETTLE : ARM;
      end
      SETTLE: begin
        i2s_en  = 1'b1;
        fifo_en = 1'b1;
        fifo_rd = ~fifo_empty;
        if (fifo_rd && (disc_cnt + 8'd1 == settle_q))
          state_nx = ARM;
      end
      ARM: begin
        i2s_en  = 1'b1;
        fifo_en = 1'b1;
        fifo_rd = ~fifo_empty;
        if (trig)
          state_nx = (len_q == '0) ? DONE : CAPTURE;
      end
      CAPTURE: begin
        i2s_en  = 1'b1;
        fifo_en = 1'b1;
        fifo_rd = ~fifo_empty & (~m_valid | m_ready)
                & (issued < len_q);
        if (accept && m_last) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    // Abort wins over everything and never pops a word.
    if (abort && state != IDLE) begin
      state_nx   = IDLE;
      fifo_flush = 1'b1;
      fifo_rd    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      len_q        <= '0;
      settle_q     <= '0;
      issued       <= '0;
      disc_cnt     <= '0;
      ext_trig_q   <= 1'b0;
      m_valid      <= 1'b0;
      m_data       <= '0;
      m_last       <= 1'b0;
      overrun      <= 1'b0;
      captured_cnt <= '0;
    end else begin
      state      <= state_nx;
      ext_trig_q <= ext_trig;
      if (go) begin
        len_q        <= capture_len;
        settle_q     <= settle_samples;
        issued       <= '0;
        disc_cnt     <= '0;
        overrun      <= 1'b0;
        captured_cnt <= '0;
      end
      if (state == SETTLE && fifo_rd)
        disc_cnt <= disc_cnt + 8'd1;
      if (state == CAPTURE && fifo_full)
        overrun <= 1'b1;
      if (state == CAPTURE && accept)
        captured_cnt <= captured_cnt + CW'(1);
      if (state == CAPTURE && !abort) begin
        if (fifo_rd) begin
          m_valid <= 1'b1;
          m_data  <= fifo_rdata;
          m_last  <= (issued + CW'(1)) == len_q;
          issued  <= issued + CW'(1);
        end else if (accept) begin
          m_valid <= 1'b0;
          m_last  <= 1'b0;
        end
      end else begin
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end
    end
  end

endmodule
